// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, flag bit positions and branch-condition selects.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0010;
    localparam logic [3:0] OP_ASR = 4'b0011;
    localparam logic [3:0] OP_LSR = 4'b0100;
    localparam logic [3:0] OP_ROL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_XOR = 4'b1011;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_MI = 3'b011;
    localparam logic [2:0] COND_PL = 3'b100;
    localparam logic [2:0] COND_CS = 3'b101;
    localparam logic [2:0] COND_VS = 3'b110;
    localparam logic [2:0] COND_LT = 3'b111;

    // Opcodes 1100-1111 are unassigned.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry FIFO of {dest, wr_en, result} with valid/ready on both sides and a registered in_ready.
module wb_skid_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic [DATA_W-1:0] in_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_wr_en,
    output logic [DATA_W-1:0] out_result
);

    localparam int unsigned ENTRY_W = REG_AW + 1 + DATA_W;

    logic [ENTRY_W-1:0] entry_q [2];
    logic [1:0]         count_q;
    logic [1:0]         count_next;
    logic               ready_q;
    logic               push;
    logic               pop;
    logic [1:0]         wr_slot;

    assign push = in_valid & ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;

    always_comb begin
        count_next = count_q;
        wr_slot    = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + 2'd1;
            2'b01:   count_next = count_q - 2'd1;
            default: count_next = count_q;
        endcase
        if (pop) wr_slot = count_q - 2'd1;
    end

    // Entry 0 is always the head; a pop shifts entry 1 down, and a same-cycle push
    // lands in the slot freed by that shift (later assignment wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= 2'd0;
            ready_q    <= 1'b0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            count_q <= count_next;
            ready_q <= (count_next < 2'(DEPTH));
            if (pop) entry_q[0] <= entry_q[1];
            if (push) entry_q[wr_slot[0]] <= {in_dest, in_wr_en, in_result};
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = (count_q != 2'd0);
    assign out_dest   = entry_q[0][ENTRY_W-1 -: REG_AW];
    assign out_wr_en  = entry_q[0][DATA_W];
    assign out_result = entry_q[0][DATA_W-1:0];

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: buffers results for the register file, tracks the architectural
// flags at acceptance time, and evaluates branch conditions for decode.
module alu_writeback_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_cc,
    input  logic [3:0]        in_aluop,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_cc_en,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    output logic [3:0]        flags,
    input  logic [2:0]        cond_sel,
    output logic              cond_true,
    output logic              illegal_op
);

    logic       accept;
    logic       illegal;
    logic       head_valid;
    logic       head_wr_en;
    logic [3:0] flags_q;
    logic       illegal_q;

    assign illegal = is_illegal_op(in_aluop);
    assign accept  = in_valid & in_ready;

    // Illegal beats still handshake on in_ready but never reach the buffer.
    wb_skid_buffer #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid & ~illegal),
        .in_ready   (in_ready),
        .in_dest    (in_dest),
        .in_wr_en   (in_wr_en),
        .in_result  (in_result),
        .out_valid  (head_valid),
        .out_ready  (rf_ready | ~head_wr_en),
        .out_dest   (rf_waddr),
        .out_wr_en  (head_wr_en),
        .out_result (rf_wdata)
    );

    assign rf_we = head_valid & head_wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept & illegal;
            if (accept & ~illegal & in_cc_en) begin
                flags_q[FLAG_N] <= in_cc[FLAG_N];
                flags_q[FLAG_Z] <= in_cc[FLAG_Z];
                if (in_aluop == OP_ADD || in_aluop == OP_SUB)
                    flags_q[FLAG_C] <= in_cc[FLAG_C];
                if (in_aluop == OP_ADD || in_aluop == OP_SUB || in_aluop == OP_SHL)
                    flags_q[FLAG_V] <= in_cc[FLAG_V];
            end
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flags_q[FLAG_Z];
            COND_NE: cond_true = ~flags_q[FLAG_Z];
            COND_MI: cond_true = flags_q[FLAG_N];
            COND_PL: cond_true = ~flags_q[FLAG_N];
            COND_CS: cond_true = flags_q[FLAG_C];
            COND_VS: cond_true = flags_q[FLAG_V];
            COND_LT: cond_true = flags_q[FLAG_N] ^ flags_q[FLAG_V];
            default: cond_true = 1'b0;
        endcase
    end

    assign flags      = flags_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_cc;
    logic [3:0]  in_aluop;
    logic [2:0]  in_dest;
    logic        in_wr_en;
    logic        in_cc_en;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rf_ready;
    logic [3:0]  flags;
    logic [2:0]  cond_sel;
    logic        cond_true;
    logic        illegal_op;

    int n_vec = 0;
    int n_err = 0;

    alu_writeback_stage #(
        .DATA_W (16),
        .REG_AW (3),
        .DEPTH  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_cc      (in_cc),
        .in_aluop   (in_aluop),
        .in_dest    (in_dest),
        .in_wr_en   (in_wr_en),
        .in_cc_en   (in_cc_en),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_ready   (rf_ready),
        .flags      (flags),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic [3:0] cc, input logic [2:0] dest,
                         input logic we, input logic ce);
        in_valid  = v;
        in_aluop  = op;
        in_result = res;
        in_cc     = cc;
        in_dest   = dest;
        in_wr_en  = we;
        in_cc_en  = ce;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        n_vec++; if (rf_waddr !== 3'd0 || rf_wdata !== 16'h0000) begin n_err++; $display("FAIL reset_rf_port got=%0d/%h exp=0/0000", rf_waddr, rf_wdata); end
        n_vec++; if (flags !== 4'b0000 || illegal_op !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b/%b exp=0000/0", flags, illegal_op); end
        reset = 1'b0;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_add();
        rf_ready = 1'b1;
        drive(1'b1, 4'b0000, 16'h0005, 4'b0000, 3'd3, 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h0005)
            begin n_err++; $display("FAIL add_write got=%b/%0d/%h exp=1/3/0005", rf_we, rf_waddr, rf_wdata); end
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL add_flags got=%b exp=0000", flags); end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL add_retired got=%b exp=0", rf_we); end
    endtask

    task automatic test_flag_update();
        drive(1'b1, 4'b0000, 16'h0000, 4'b0010, 3'd0, 1'b0, 1'b1);
        tick();
        n_vec++; if (flags !== 4'b0010) begin n_err++; $display("FAIL flags_add got=%b exp=0010", flags); end
        drive(1'b1, 4'b1011, 16'h0000, 4'b1000, 3'd0, 1'b0, 1'b1);
        tick();
        n_vec++; if (flags !== 4'b1010) begin n_err++; $display("FAIL flags_xor_c_held got=%b exp=1010", flags); end
        drive(1'b1, 4'b0001, 16'h0000, 4'b0100, 3'd0, 1'b0, 1'b1);
        cond_sel = 3'b101;
        #1;
        n_vec++; if (cond_true !== 1'b1) begin n_err++; $display("FAIL cond_pre_update got=%b exp=1", cond_true); end
        tick();
        n_vec++; if (flags !== 4'b0100) begin n_err++; $display("FAIL flags_sub got=%b exp=0100", flags); end
        n_vec++; if (cond_true !== 1'b0) begin n_err++; $display("FAIL cond_post_update got=%b exp=0", cond_true); end
        // SHL: C held at 0, V taken
        drive(1'b1, 4'b0010, 16'h0000, 4'b0011, 3'd0, 1'b0, 1'b1);
        tick();
        n_vec++; if (flags !== 4'b0001) begin n_err++; $display("FAIL flags_shl got=%b exp=0001", flags); end
        drive(1'b1, 4'b0000, 16'h0000, 4'b1111, 3'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (flags !== 4'b0001) begin n_err++; $display("FAIL flags_cc_en_off got=%b exp=0001", flags); end
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_cond_sweep();
        logic [7:0] exp_tbl;
        exp_tbl = 8'b0100_1101;
        drive(1'b1, 4'b0000, 16'h0000, 4'b1001, 3'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        n_vec++; if (flags !== 4'b1001) begin n_err++; $display("FAIL sweep_flags got=%b exp=1001", flags); end
        for (int i = 0; i < 8; i++) begin
            cond_sel = 3'(i);
            #1;
            n_vec++; if (cond_true !== exp_tbl[i])
                begin n_err++; $display("FAIL cond_sel_%0d got=%b exp=%b", i, cond_true, exp_tbl[i]); end
        end
    endtask

    task automatic test_illegal();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_pre_ready got=%b exp=1", in_ready); end
        drive(1'b1, 4'b1100, 16'hBEEF, 4'b1111, 3'd6, 1'b1, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        n_vec++; if (illegal_op !== 1'b1) begin n_err++; $display("FAIL illegal_pulse got=%b exp=1", illegal_op); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL illegal_no_write got=%b exp=0", rf_we); end
        n_vec++; if (flags !== 4'b1001) begin n_err++; $display("FAIL illegal_flags got=%b exp=1001", flags); end
        tick();
        n_vec++; if (illegal_op !== 1'b0) begin n_err++; $display("FAIL illegal_one_cycle got=%b exp=0", illegal_op); end
    endtask

    task automatic test_back_to_back();
        rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1000, 16'h0A00 + 16'(i), 4'b0000, 3'(4 + i), 1'b1, 1'b0);
            tick();
            n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 3'(4 + i) || rf_wdata !== 16'h0A00 + 16'(i))
                begin n_err++; $display("FAIL b2b_write_%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 4 + i, 16'h0A00 + 16'(i)); end
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
        end
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", rf_we); end
    endtask

    task automatic test_backpressure();
        rf_ready = 1'b0;
        drive(1'b1, 4'b0000, 16'h1111, 4'b0000, 3'd1, 1'b1, 1'b0);
        tick();
        n_vec++; if (in_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 3'd1)
            begin n_err++; $display("FAIL bp_first got=%b/%b/%0d exp=1/1/1", in_ready, rf_we, rf_waddr); end
        drive(1'b1, 4'b0000, 16'h2222, 4'b0000, 3'd2, 1'b1, 1'b0);
        tick();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        drive(1'b1, 4'b0000, 16'h3333, 4'b0000, 3'd3, 1'b1, 1'b0);
        tick();
        tick();
        n_vec++; if (in_ready !== 1'b0 || rf_waddr !== 3'd1 || rf_wdata !== 16'h1111)
            begin n_err++; $display("FAIL bp_hold got=%b/%0d/%h exp=0/1/1111", in_ready, rf_waddr, rf_wdata); end
        rf_ready = 1'b1;
        tick();
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 16'h2222 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL bp_second got=%b/%0d/%h/%b exp=1/2/2222/1", rf_we, rf_waddr, rf_wdata, in_ready); end
        tick();
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 3'd3 || rf_wdata !== 16'h3333)
            begin n_err++; $display("FAIL bp_third got=%b/%0d/%h exp=1/3/3333", rf_we, rf_waddr, rf_wdata); end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got=%b exp=0", rf_we); end
    endtask

    task automatic test_reset_midflight();
        rf_ready = 1'b0;
        drive(1'b1, 4'b0000, 16'h4444, 4'b1111, 3'd5, 1'b1, 1'b1);
        tick();
        drive(1'b1, 4'b0000, 16'h5555, 4'b1111, 3'd6, 1'b1, 1'b1);
        tick();
        n_vec++; if (in_ready !== 1'b0 || flags !== 4'b1111)
            begin n_err++; $display("FAIL rst_mid_setup got=%b/%b exp=0/1111", in_ready, flags); end
        reset = 1'b1;
        drive(1'b1, 4'b0000, 16'h6666, 4'b1111, 3'd7, 1'b1, 1'b1);
        tick();
        n_vec++; if (rf_we !== 1'b0 || flags !== 4'b0000 || in_ready !== 1'b0 || rf_waddr !== 3'd0)
            begin n_err++; $display("FAIL rst_mid_clear got=%b/%b/%b/%0d exp=0/0000/0/0", rf_we, flags, in_ready, rf_waddr); end
        reset = 1'b0;
        rf_ready = 1'b1;
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        tick();
        n_vec++; if (in_ready !== 1'b1 || rf_we !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_after got=%b/%b exp=1/0", in_ready, rf_we); end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale got=%b exp=0", rf_we); end
    endtask

    initial begin
        reset    = 1'b1;
        rf_ready = 1'b0;
        cond_sel = 3'b000;
        drive(1'b0, 4'b0000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0);
        test_reset();
        test_single_add();
        test_flag_update();
        test_cond_sweep();
        test_illegal();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU.
- Captures the ALU result, cc {N,Z,C,V} and instruction tags through a valid/ready handshake, and buffers them in a 2-entry skid buffer.
- Drives the register-file write port and maintains the architectural flag register.
- Exposes a branch-condition evaluator for the decode stage.

Parameters:
- DATA_W, 16, ALU result width.
- REG_AW, 3, register-file address width (8 registers).
- DEPTH, 2, skid-buffer entries; fixed at 2 (other values unsupported).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  ALU-side beat valid.
- in_ready  output  1  stage can accept a beat.
- in_result  input  DATA_W  ALU result.
- in_cc  input  4  ALU flags {N,Z,C,V}.
- in_aluop  input  4  opcode the ALU executed.
- in_dest  input  REG_AW  destination register.
- in_wr_en  input  1  beat writes the register file.
- in_cc_en  input  1  beat updates flags.
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  REG_AW  write address.
- rf_wdata  output  DATA_W  write data.
- rf_ready  input  1  register file accepts the write this cycle.
- flags  output  4  architectural {N,Z,C,V}.
- cond_sel  input  3  condition select.
- cond_true  output  1  condition evaluated on flags.
- illegal_op  output  1  one-cycle pulse on an accepted illegal opcode.

Behaviour:
- Reset: all of the following clear in the cycle reset is sampled high, regardless of in-flight beats, and stored beats are discarded.
  - buffer count = 0
  - in_ready = 0 during reset, 1 the cycle after
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - flags = 4'b0000, illegal_op = 0
- Handshake:
  - Beat accepted when in_valid & in_ready.
  - in_ready is registered: 1 iff count < 2 after the current cycle's updates.
  - Head entry retires when rf_ready is 1 or the entry's wr_en is 0.
  - Accept and retire in the same cycle: count unchanged, order preserved (FIFO).
  - Full (count = 2) with no retire: in_ready = 0, inputs ignored.
  - Empty with accept: entry visible at the head the next cycle (1-cycle latency from accept to rf_we).
- RF port: rf_we = head valid & head wr_en; rf_waddr/rf_wdata driven from the head entry; held stable while rf_ready = 0.
- Flag update:
  - Occurs at acceptance, not retirement, so branches see flags 1 cycle after accept.
  - Applies only if in_cc_en = 1 and the opcode is legal.
  - N, Z: always take in_cc.
  - C: updates only for aluop 0000/0001; otherwise held.
  - V: updates only for aluop 0000/0001/0010; otherwise held.
- Illegal opcode (1100-1111):
  - Beat is accepted but not buffered, and no flag update occurs.
  - illegal_op = 1 for exactly the next cycle.
- cond_true is combinational from flags:
  - 000 always
  - 001 Z
  - 010 ~Z
  - 011 N
  - 100 ~N
  - 101 C
  - 110 V
  - 111 N^V (signed less-than)
- Simultaneous accept and flag read: cond_true reflects pre-update flags that cycle.

Decomposition:
- Shared package cpu_pkg:
  - aluop constants: ADD=0000, SUB=0001, SHL=0010, ASR=0011, LSR=0100, ROL=0101, ROR=0110, MUL=0111, AND=1000, OR=1001, NOT=1010, XOR=1011.
  - flag bit indices N=3, Z=2, C=1, V=0.
  - cond_sel encodings.
- One sub-module: wb_skid_buffer (2-entry FIFO of {dest, wr_en, result}, valid/ready both sides).
- Flag logic and condition evaluation stay in the top level.

Test Plan:
- Reset then a single ADD beat: result=0x0005, cc=0000, dest=3, wr_en=1, cc_en=1, rf_ready=1 -> next cycle rf_we=1, waddr=3, wdata=0x0005; flags=0000.
- SUB sets C=0 after ADD set C=1: ADD cc=0010, then XOR cc=1000, then SUB cc=0100 -> flags 0010, then 1010 (C kept), then 0100.
- Backpressure: rf_ready=0, three back-to-back beats -> in_ready drops after the 2nd; the 3rd is held until rf_ready=1; writes emerge in order with no loss or duplication.
- Illegal opcode 1100 with cc_en=1, cc=1111 -> flags unchanged, no rf_we, illegal_op high one cycle.
- cond_sel sweep with flags=1001 -> 000:1, 001:0, 010:1, 011:1, 100:0, 101:0, 110:1, 111:0.
- Reset asserted with 2 buffered beats and rf_ready=0 -> next cycle rf_we=0, flags=0000, in_ready=1 the following cycle, with no stale write.
